// File: rtl/radix3_pkg.sv
// Shared types, constants and arithmetic helpers for the radix-3 butterfly stage.
package radix3_pkg;

  localparam int unsigned LANE_W = 32;
  localparam int unsigned CW     = 16;

  localparam logic signed [39:0] K_SQRT3_2 = 40'sd28378;
  localparam logic signed [39:0] RND_Q15   = 40'sd16384;
  localparam logic signed [39:0] SAT_MAX   = 40'sd32767;
  localparam logic signed [39:0] SAT_MIN   = -40'sd32768;

  typedef struct packed {
    logic [CW-1:0] re;
    logic [CW-1:0] im;
  } cplx_t;

  function automatic cplx_t cplx_unpack(input logic [LANE_W-1:0] v);
    return cplx_t'(v);
  endfunction

  function automatic logic [LANE_W-1:0] cplx_pack(input cplx_t v);
    return v;
  endfunction

  // Q1.15 product rounding: round half up, then arithmetic shift.
  function automatic logic signed [39:0] rnd_q15(input logic signed [39:0] p);
    return (p + RND_Q15) >>> 15;
  endfunction

  function automatic logic [CW-1:0] sat16(input logic signed [39:0] v);
    if (v > SAT_MAX)
      return 16'h7FFF;
    else if (v < SAT_MIN)
      return 16'h8000;
    else
      return v[CW-1:0];
  endfunction

endpackage

// File: rtl/radix3_bf_if.sv
// Lane/result bundle between the shuffler, the butterfly stage and its consumer.
interface radix3_bf_if;
  import radix3_pkg::*;

  logic              start;
  logic              in_valid;
  logic [LANE_W-1:0] a;
  logic [LANE_W-1:0] b;
  logic [LANE_W-1:0] c;
  logic              out_valid;
  logic [LANE_W-1:0] x0;
  logic [LANE_W-1:0] x1;
  logic [LANE_W-1:0] x2;
  logic [7:0]        tw_idx;

  modport master (
    output start, in_valid, a, b, c,
    input  out_valid, x0, x1, x2, tw_idx
  );

  modport slave (
    input  start, in_valid, a, b, c,
    output out_valid, x0, x1, x2, tw_idx
  );
endinterface

// File: rtl/radix3_bf_stage_twiddle_rom.sv
// Combinational twiddle table: w = {cos, -sin} of 2*pi*idx/N in Q1.15.
module twiddle_rom import radix3_pkg::*; #(
  parameter int unsigned N = 9
) (
  input  logic [7:0]        idx,
  output logic [LANE_W-1:0] w
);

  always_comb begin
    w = {16'sd32767, 16'sd0};
    if (N == 9) begin
      case (idx)
        8'd0:    w = {16'sd32767,  16'sd0};
        8'd1:    w = {16'sd25102, -16'sd21063};
        8'd2:    w = {16'sd5690,  -16'sd32270};
        8'd3:    w = {-16'sd16384, -16'sd28378};
        8'd4:    w = {-16'sd30792, -16'sd11207};
        8'd5:    w = {-16'sd30792,  16'sd11207};
        8'd6:    w = {-16'sd16384,  16'sd28378};
        8'd7:    w = {16'sd5690,   16'sd32270};
        8'd8:    w = {16'sd25102,  16'sd21063};
        default: w = {16'sd32767,  16'sd0};
      endcase
    end
  end

endmodule

// File: rtl/radix3_bf_stage.sv
// Four-stage radix-3 butterfly: sum/diff, 3-point DFT, twiddle multiply, shift and saturate.
module radix3_bf_stage import radix3_pkg::*; #(
  parameter int unsigned N     = 9,
  parameter int unsigned SHIFT = 1,
  parameter bit          TW_EN = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  radix3_bf_if.slave bus
);

  localparam int unsigned NGRP = N / 3;

  cplx_t a_c, b_c, c_c;
  logic signed [15:0] ar, ai, br, bi, cr, ci;

  assign a_c = cplx_unpack(bus.a);
  assign b_c = cplx_unpack(bus.b);
  assign c_c = cplx_unpack(bus.c);
  assign ar  = $signed(a_c.re);
  assign ai  = $signed(a_c.im);
  assign br  = $signed(b_c.re);
  assign bi  = $signed(b_c.im);
  assign cr  = $signed(c_c.re);
  assign ci  = $signed(c_c.im);

  // start overrides the stored count so a same-cycle sample is tagged n=0.
  logic [7:0] n_q, n_cur, n_nxt;
  always_comb begin
    n_cur = bus.start ? '0 : n_q;
    n_nxt = n_cur;
    if (bus.in_valid)
      n_nxt = (n_cur == 8'(NGRP - 1)) ? '0 : n_cur + 8'd1;
  end

  logic               v1;
  logic [7:0]         n1;
  logic signed [15:0] ar1, ai1;
  logic signed [16:0] tr1, ti1, dr1, di1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0;
      v1  <= 1'b0;
      n1  <= '0;
      ar1 <= '0;
      ai1 <= '0;
      tr1 <= '0;
      ti1 <= '0;
      dr1 <= '0;
      di1 <= '0;
    end else begin
      n_q <= n_nxt;
      v1  <= bus.in_valid;
      n1  <= n_cur;
      ar1 <= ar;
      ai1 <= ai;
      tr1 <= 17'(br) + 17'(cr);
      ti1 <= 17'(bi) + 17'(ci);
      dr1 <= 17'(br) - 17'(cr);
      di1 <= 17'(bi) - 17'(ci);
    end
  end

  logic signed [39:0] mr, mi, hr, hi;
  always_comb begin
    mr = rnd_q15(40'(dr1) * K_SQRT3_2);
    mi = rnd_q15(40'(di1) * K_SQRT3_2);
    hr = 40'(ar1) - (40'(tr1) >>> 1);
    hi = 40'(ai1) - (40'(ti1) >>> 1);
  end

  logic               v2;
  logic [7:0]         n2;
  logic signed [18:0] x0r2, x0i2, x1r2, x1i2, x2r2, x2i2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      n2   <= '0;
      x0r2 <= '0;
      x0i2 <= '0;
      x1r2 <= '0;
      x1i2 <= '0;
      x2r2 <= '0;
      x2i2 <= '0;
    end else begin
      v2   <= v1;
      n2   <= n1;
      x0r2 <= 19'(40'(ar1) + 40'(tr1));
      x0i2 <= 19'(40'(ai1) + 40'(ti1));
      x1r2 <= 19'(hr + mi);
      x1i2 <= 19'(hi - mr);
      x2r2 <= 19'(hr - mi);
      x2i2 <= 19'(hi + mr);
    end
  end

  logic [8:0]        dbl;
  logic [7:0]        idx1, idx2;
  logic [LANE_W-1:0] w1, w2;
  logic              bypass;

  assign dbl    = {n2, 1'b0};
  assign idx1   = n2;
  assign idx2   = (dbl >= 9'(N)) ? 8'(dbl - 9'(N)) : dbl[7:0];
  // W^0 = 32767 is not exactly 1.0, so n=0 skips the multiply to stay bit-exact.
  assign bypass = !TW_EN || (n2 == '0);

  twiddle_rom #(.N(N)) u_rom1 (.idx(idx1), .w(w1));
  twiddle_rom #(.N(N)) u_rom2 (.idx(idx2), .w(w2));

  function automatic logic signed [39:0] tw_re(input logic signed [18:0] xr,
                                               input logic signed [18:0] xi,
                                               input logic [LANE_W-1:0] w);
    return rnd_q15(40'(xr) * 40'($signed(w[31:16])))
         - rnd_q15(40'(xi) * 40'($signed(w[15:0])));
  endfunction

  function automatic logic signed [39:0] tw_im(input logic signed [18:0] xr,
                                               input logic signed [18:0] xi,
                                               input logic [LANE_W-1:0] w);
    return rnd_q15(40'(xr) * 40'($signed(w[15:0])))
         + rnd_q15(40'(xi) * 40'($signed(w[31:16])));
  endfunction

  logic               v3;
  logic [7:0]         n3;
  logic signed [21:0] y0r3, y0i3, y1r3, y1i3, y2r3, y2i3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      n3   <= '0;
      y0r3 <= '0;
      y0i3 <= '0;
      y1r3 <= '0;
      y1i3 <= '0;
      y2r3 <= '0;
      y2i3 <= '0;
    end else begin
      v3   <= v2;
      n3   <= n2;
      y0r3 <= 22'(x0r2);
      y0i3 <= 22'(x0i2);
      y1r3 <= bypass ? 22'(x1r2) : 22'(tw_re(x1r2, x1i2, w1));
      y1i3 <= bypass ? 22'(x1i2) : 22'(tw_im(x1r2, x1i2, w1));
      y2r3 <= bypass ? 22'(x2r2) : 22'(tw_re(x2r2, x2i2, w2));
      y2i3 <= bypass ? 22'(x2i2) : 22'(tw_im(x2r2, x2i2, w2));
    end
  end

  logic              ov_q;
  logic [7:0]        tw_q;
  logic [LANE_W-1:0] x0_q, x1_q, x2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      tw_q <= '0;
      x0_q <= '0;
      x1_q <= '0;
      x2_q <= '0;
    end else begin
      ov_q <= v3;
      tw_q <= n3;
      x0_q <= {sat16(40'(y0r3) >>> SHIFT), sat16(40'(y0i3) >>> SHIFT)};
      x1_q <= {sat16(40'(y1r3) >>> SHIFT), sat16(40'(y1i3) >>> SHIFT)};
      x2_q <= {sat16(40'(y2r3) >>> SHIFT), sat16(40'(y2i3) >>> SHIFT)};
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.tw_idx    = tw_q;
  assign bus.x0        = x0_q;
  assign bus.x1        = x1_q;
  assign bus.x2        = x2_q;

endmodule

// File: tb/tb_radix3_bf_stage.sv
// Directed bench: three configurations of radix3_bf_stage driven in lockstep.
`timescale 1ns/1ps
module tb_radix3_bf_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  radix3_bf_if bif0 ();
  radix3_bf_if bif1 ();
  radix3_bf_if bif2 ();

  radix3_bf_stage #(.N(9), .SHIFT(0), .TW_EN(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bif0.slave));
  radix3_bf_stage #(.N(9), .SHIFT(0), .TW_EN(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bif1.slave));
  radix3_bf_stage #(.N(9), .SHIFT(1), .TW_EN(1'b1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bif2.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // start / in_valid / expected n per cycle of the counter stream
  int st_t [14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
  int vl_t [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1};
  int ex_t [14] = '{0, 1, 2, 0, 1, 2, 0, 1, 0, 2, 0, 1, 0, 0};

  function automatic logic [31:0] cx(input int re, input int im);
    return {16'(re), 16'(im)};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input int st, input int vl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    bif0.start = st[0]; bif0.in_valid = vl[0]; bif0.a = a; bif0.b = b; bif0.c = c;
    bif1.start = st[0]; bif1.in_valid = vl[0]; bif1.a = a; bif1.b = b; bif1.c = c;
    bif2.start = st[0]; bif2.in_valid = vl[0]; bif2.a = a; bif2.b = b; bif2.c = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sample, returns just after the edge where its result is registered.
  task automatic send1(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    drive(0, 1, a, b, c);
    step();
    drive(0, 0, '0, '0, '0);
    step();
    step();
    check({tag, "_early"}, 32'(bif0.out_valid), 32'd0);
    step();
    check({tag, "_ov"}, 32'(bif0.out_valid), 32'd1);
  endtask

  initial begin
    drive(0, 0, '0, '0, '0);
    rst_n = 1'b0;
    step();
    step();
    check("rst_ov", 32'(bif1.out_valid), 32'd0);
    check("rst_x0", bif1.x0, 32'd0);
    check("rst_tw", 32'(bif1.tw_idx), 32'd0);
    rst_n = 1'b1;
    step();

    send1("t1", cx(1000, 0), '0, '0);
    check("t1_x0", bif0.x0, cx(1000, 0));
    check("t1_x1", bif0.x1, cx(1000, 0));
    check("t1_x2", bif0.x2, cx(1000, 0));
    step();
    check("t1_pulse", 32'(bif0.out_valid), 32'd0);

    send1("t2", '0, cx(1000, 0), '0);
    check("t2_x0", bif0.x0, cx(1000, 0));
    check("t2_x1", bif0.x1, cx(-500, -866));
    check("t2_x2", bif0.x2, cx(-500, 866));
    check("t2_tw", 32'(bif0.tw_idx), 32'd1);

    send1("t3", cx(32767, 0), cx(32767, 0), cx(32767, 0));
    check("t3_x0", bif0.x0, cx(32767, 0));
    check("t3_x1", bif0.x1, cx(0, 0));
    check("t3_x2", bif0.x2, cx(0, 0));
    check("t3_sh_x0", bif2.x0, cx(32767, 0));
    check("t3_sh_x1", bif2.x1, cx(0, 0));

    send1("t3n", cx(-32768, -32768), cx(-32768, -32768), cx(-32768, -32768));
    check("t3n_x0", bif0.x0, cx(-32768, -32768));
    check("t3n_x1", bif0.x1, cx(0, 0));
    check("t3n_tw", 32'(bif0.tw_idx), 32'd0);
    check("t3n_sh_x0", bif2.x0, cx(-32768, -32768));

    drive(1, 0, '0, '0, '0);
    step();
    drive(0, 1, cx(1000, 0), '0, '0);
    step();
    step();
    drive(0, 0, '0, '0, '0);
    step();
    step();
    check("t4a_ov", 32'(bif1.out_valid), 32'd1);
    check("t4a_tw", 32'(bif1.tw_idx), 32'd0);
    check("t4a_x1", bif1.x1, cx(1000, 0));
    check("t4a_x2", bif1.x2, cx(1000, 0));
    step();
    check("t4b_ov", 32'(bif1.out_valid), 32'd1);
    check("t4b_tw", 32'(bif1.tw_idx), 32'd1);
    check("t4b_x0", bif1.x0, cx(1000, 0));
    check("t4b_x1", bif1.x1, cx(766, -643));
    check("t4b_x2", bif1.x2, cx(174, -985));
    check("t4b_sh_x0", bif2.x0, cx(500, 0));
    check("t4b_sh_x1", bif2.x1, cx(383, -322));
    check("t4b_sh_x2", bif2.x2, cx(87, -493));

    for (int i = 0; i < 17; i++) begin
      if (i < 14) drive(st_t[i], vl_t[i], cx(i, 0), '0, '0);
      else        drive(0, 0, '0, '0, '0);
      step();
      if (i >= 3) begin
        check($sformatf("t5_ov%0d", i - 3), 32'(bif1.out_valid), 32'(vl_t[i-3]));
        if (vl_t[i-3] != 0)
          check($sformatf("t5_n%0d", i - 3), 32'(bif1.tw_idx), 32'(ex_t[i-3]));
      end
    end

    drive(0, 1, cx(2000, 0), '0, '0);
    step();
    step();
    step();
    drive(0, 0, '0, '0, '0);
    step();
    check("t6_pre_ov", 32'(bif1.out_valid), 32'd1);
    check("t6_pre_tw", 32'(bif1.tw_idx), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ov", 32'(bif1.out_valid), 32'd0);
    check("t6_rst_x0", bif1.x0, 32'd0);
    check("t6_rst_tw", 32'(bif1.tw_idx), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("t6_quiet%0d", i), 32'(bif1.out_valid), 32'd0);
    end
    send1("t6_post", cx(100, 0), '0, '0);
    check("t6_post_tw", 32'(bif1.tw_idx), 32'd0);
    check("t6_post_x1", bif1.x1, cx(100, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
